// File: rtl/mod_ring_pkg.sv
// rtl/mod_ring_pkg.sv - shared ModRing types and helpers
// Purpose : FSM state encoding and operation-length helper shared by the
//           ModRing arithmetic blocks.
// Ports   : none (package)
package mod_ring_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } ring_state_t;

   // Number of coefficients processed by one operation.
   function automatic int unsigned op_len(input int unsigned n_log);
      return 32'd1 << n_log;
   endfunction

endpackage

// File: rtl/mod_sub_stream_if.sv
// rtl/mod_sub_stream_if.sv - command and stream bundle for mod_sub_stream
// Purpose : groups the command (start/q_in/busy/done), operand stream and
//           result stream of the modular subtractor.
// Ports   : start, q_in, busy, done        command interface
//           in_valid, in_ready, ina, inb   operand stream
//           out_valid, out_ready, out,
//           out_last                       result stream
// Modports: master drives commands/operands, slave is the subtractor.
interface mod_sub_stream_if #(
   parameter int K = 54
);
   logic         start;
   logic [K-1:0] q_in;
   logic         busy;
   logic         done;
   logic         in_valid;
   logic         in_ready;
   logic [K-1:0] ina;
   logic [K-1:0] inb;
   logic         out_valid;
   logic         out_ready;
   logic [K-1:0] out;
   logic         out_last;

   modport master (
      output start, q_in, in_valid, ina, inb, out_ready,
      input  busy, done, in_ready, out_valid, out, out_last
   );

   modport slave (
      input  start, q_in, in_valid, ina, inb, out_ready,
      output busy, done, in_ready, out_valid, out, out_last
   );
endinterface

// File: rtl/mod_sub_core.sv
// rtl/mod_sub_core.sv - two-stage modular subtract datapath
// Purpose : res = (ina - inb) mod q over two pipeline stages with a per-stage
//           advance enable, valid bit and last tag.
// Ports   : clk, rst          clock, synchronous active-high reset (valid bits only)
//           q                 modulus, constant while data is in flight
//           adv1, adv2        stage load enables
//           in_fire, in_last  new operand pair present / final-coefficient tag
//           ina, inb          operands
//           s1_valid,s2_valid stage occupancy
//           res, res_last     stage-2 result and its last tag
module mod_sub_core #(
   parameter int K = 54
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [K-1:0] q,
   input  logic         adv1,
   input  logic         adv2,
   input  logic         in_fire,
   input  logic         in_last,
   input  logic [K-1:0] ina,
   input  logic [K-1:0] inb,
   output logic         s1_valid,
   output logic         s2_valid,
   output logic [K-1:0] res,
   output logic         res_last
);

   logic [K:0]   diff;
   logic [K:0]   s1_diff;
   logic         s1_last;
   logic [K-1:0] wrapped;

   // One extra bit so the top bit is the borrow of ina - inb.
   assign diff    = {1'b0, ina} - {1'b0, inb};
   // On borrow the low K bits hold ina - inb + 2^K; adding q and dropping
   // the carry yields ina - inb + q.
   assign wrapped = s1_diff[K-1:0] + q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (adv1) s1_valid <= in_fire;
         if (adv2) s2_valid <= s1_valid;
      end
   end

   // Data registers carry no reset; their contents only matter under valid.
   always_ff @(posedge clk) begin
      if (adv1) begin
         s1_diff <= diff;
         s1_last <= in_last;
      end
      if (adv2) begin
         res      <= s1_diff[K] ? wrapped : s1_diff[K-1:0];
         res_last <= s1_last;
      end
   end

endmodule

// File: rtl/mod_sub_stream.sv
// rtl/mod_sub_stream.sv - streaming modular subtractor with command FSM
// Purpose : computes out = (ina - inb) mod q for 2^N_LOG coefficients per
//           start command, with valid/ready flow control on both streams.
// Ports   : clk  clock, all logic on posedge
//           rst  synchronous active-high reset
//           bus  mod_sub_stream_if.slave: start/q_in/busy/done command,
//                in_valid/in_ready/ina/inb operands,
//                out_valid/out_ready/out/out_last results
module mod_sub_stream #(
   parameter int K     = 54,
   parameter int N_LOG = 12
) (
   input  logic              clk,
   input  logic              rst,
   mod_sub_stream_if.slave   bus
);
   import mod_ring_pkg::*;

   localparam int unsigned      OP_LEN   = op_len(N_LOG);
   localparam logic [N_LOG-1:0] LAST_IDX = N_LOG'(OP_LEN - 1);

   ring_state_t      state;
   logic [N_LOG-1:0] cnt;
   logic [K-1:0]     q_reg;
   logic             busy_r;
   logic             done_r;

   logic             adv1;
   logic             adv2;
   logic             in_ready;
   logic             in_fire;
   logic             out_fire;
   logic             s1_valid;
   logic             s2_valid;
   logic [K-1:0]     core_res;
   logic             core_last;

   assign adv2     = !s2_valid || bus.out_ready;
   assign adv1     = !s1_valid || adv2;
   assign in_ready = (state == RUN) && adv1;
   assign in_fire  = bus.in_valid && in_ready;
   assign out_fire = s2_valid && bus.out_ready;

   mod_sub_core #(.K(K)) u_core (
      .clk      (clk),
      .rst      (rst),
      .q        (q_reg),
      .adv1     (adv1),
      .adv2     (adv2),
      .in_fire  (in_fire),
      .in_last  (cnt == LAST_IDX),
      .ina      (bus.ina),
      .inb      (bus.inb),
      .s1_valid (s1_valid),
      .s2_valid (s2_valid),
      .res      (core_res),
      .res_last (core_last)
   );

   // Result fields read as zero when no result is presented, which also
   // covers the reset state of the unreset data registers.
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = s2_valid;
   assign bus.out       = s2_valid ? core_res : '0;
   assign bus.out_last  = s2_valid && core_last;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         q_reg  <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  q_reg  <= bus.q_in;
                  cnt    <= '0;
                  busy_r <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (in_fire) begin
                  // Wraps naturally to zero after the last coefficient.
                  cnt <= cnt + N_LOG'(1);
                  if (cnt == LAST_IDX) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (out_fire && core_last) begin
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: begin
               busy_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mod_sub_stream.sv
// tb/tb_mod_sub_stream.sv - self-checking bench for mod_sub_stream
module tb_mod_sub_stream;

   localparam logic [53:0] Q1   = 54'd17;
   localparam logic [53:0] Q2   = 54'h3F_FFFF_FFFF_FFDF;
   localparam logic [53:0] Q2M1 = 54'h3F_FFFF_FFFF_FFDE;

   typedef struct {
      logic [53:0] a;
      logic [53:0] b;
      logic [53:0] e;
      bit          chk;
   } vec_t;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_chk;
   vec_t vt [20];

   mod_sub_stream_if #(.K(54)) ifa ();
   mod_sub_stream_if #(.K(54)) ifb ();

   mod_sub_stream #(.K(54), .N_LOG(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   mod_sub_stream #(.K(54), .N_LOG(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
   endtask

   // One 4-coefficient operation on dut_a using table entries base..base+3.
   task automatic op_a(input int base, input bit do_start, input logic [53:0] q,
                       input bit poke, input bit chain, input logic [53:0] qn);
      int sent, got, last_c;
      int acc [4];
      bit fin;
      sent = 0; got = 0; last_c = -10; fin = 0;
      ifa.out_ready = 1'b1;
      if (do_start) begin
         ifa.start = 1'b1; ifa.q_in = q;
         #1;
         check("busy_idle", ifa.busy, 0);
         cyc();
         ifa.start = 1'b0; ifa.q_in = '1;
      end
      check("busy_run", ifa.busy, 1);
      for (int c = 0; c < 60 && !fin; c++) begin
         if (ifa.done) begin
            fin = 1;
            check("done_time", c, last_c + 1);
            check("busy_done", ifa.busy, 0);
            ifa.in_valid = 1'b0;
            if (chain) begin
               ifa.start = 1'b1; ifa.q_in = qn;
               cyc();
               ifa.start = 1'b0;
            end else begin
               cyc();
               check("done_once", ifa.done, 0);
            end
         end else begin
            ifa.start = poke && (c == 1);
            if (poke && c == 1) ifa.q_in = 54'd99;
            ifa.in_valid = (sent < 4);
            if (sent < 4) begin
               ifa.ina = vt[base+sent].a;
               ifa.inb = vt[base+sent].b;
            end
            #1;
            if (ifa.out_valid && got < 4) begin
               if (vt[base+got].chk) check("out_val", ifa.out, vt[base+got].e);
               check("out_last", ifa.out_last, got == 3);
               check("latency", c - acc[got], 2);
               got++;
               if (got == 4) last_c = c;
            end else if (ifa.out_valid) begin
               check("extra_out", got, 3);
            end
            if (ifa.in_valid && ifa.in_ready) begin
               acc[sent] = c;
               sent++;
            end
            cyc();
         end
      end
      ifa.start = 1'b0;
      check("op_finished", fin, 1);
   endtask

   initial begin
      bit          seen_done;
      int          sent, got, dones, quiet;
      bit          pstall;
      logic [53:0] pout;
      logic        plast;

      n_pass = 0; n_chk = 0;
      vt[0]  = '{54'd3,  54'd5,  54'd15, 1'b1};
      vt[1]  = '{54'd5,  54'd3,  54'd2,  1'b1};
      vt[2]  = '{54'd7,  54'd7,  54'd0,  1'b1};
      vt[3]  = '{54'd0,  54'd16, 54'd1,  1'b1};
      vt[4]  = '{54'd0,  Q2M1,   54'd1,  1'b1};
      vt[5]  = '{Q2M1,   54'd0,  Q2M1,   1'b1};
      vt[6]  = '{54'd1,  54'd2,  Q2M1,   1'b1};
      vt[7]  = '{Q2M1,   Q2M1,   54'd0,  1'b1};
      vt[8]  = '{54'd20, 54'd1,  54'd0,  1'b0};
      vt[9]  = '{54'd2,  54'd1,  54'd1,  1'b1};
      vt[10] = '{54'd4,  54'd9,  54'd12, 1'b1};
      vt[11] = '{54'd16, 54'd0,  54'd16, 1'b1};
      vt[12] = '{54'd1,  54'd2,  54'd16, 1'b1};
      vt[13] = '{54'd2,  54'd1,  54'd1,  1'b1};
      vt[14] = '{54'd10, 54'd15, 54'd12, 1'b1};
      vt[15] = '{54'd15, 54'd10, 54'd5,  1'b1};
      vt[16] = '{54'd16, 54'd16, 54'd0,  1'b1};
      vt[17] = '{54'd0,  54'd1,  54'd16, 1'b1};
      vt[18] = '{54'd8,  54'd0,  54'd8,  1'b1};
      vt[19] = '{54'd9,  54'd13, 54'd13, 1'b1};

      ifa.start = 0; ifa.q_in = '0; ifa.in_valid = 0; ifa.ina = '0; ifa.inb = '0; ifa.out_ready = 1;
      ifb.start = 0; ifb.q_in = '0; ifb.in_valid = 0; ifb.ina = '0; ifb.inb = '0; ifb.out_ready = 1;
      rst = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;
      #1;
      check("rst_busy",      ifa.busy, 0);
      check("rst_done",      ifa.done, 0);
      check("rst_in_ready",  ifa.in_ready, 0);
      check("rst_out_valid", ifa.out_valid, 0);
      check("rst_out_last",  ifa.out_last, 0);
      check("rst_out",       ifa.out, 0);

      op_a(0, 1, Q1, 0, 0, '0);
      op_a(4, 1, Q2, 0, 0, '0);
      op_a(0, 1, Q1, 1, 1, Q2);
      op_a(4, 0, Q2, 0, 0, '0);

      // Reset while one result is stalled and another sits in stage 1.
      ifa.start = 1'b1; ifa.q_in = Q1;
      cyc();
      ifa.start = 1'b0;
      ifa.out_ready = 1'b0;
      ifa.in_valid = 1'b1; ifa.ina = 54'd3; ifa.inb = 54'd5;
      #1;
      check("mid_acc0", ifa.in_ready, 1);
      cyc();
      ifa.ina = 54'd5; ifa.inb = 54'd3;
      #1;
      check("mid_acc1", ifa.in_ready, 1);
      cyc();
      ifa.in_valid = 1'b0;
      #1;
      check("mid_stall_valid", ifa.out_valid, 1);
      check("mid_stall_out", ifa.out, 15);
      check("mid_full", ifa.in_ready, 0);
      cyc();
      #1;
      check("mid_hold_out", ifa.out, 15);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      ifa.out_ready = 1'b1;
      #1;
      check("mid_rst_busy",  ifa.busy, 0);
      check("mid_rst_valid", ifa.out_valid, 0);
      check("mid_rst_out",   ifa.out, 0);
      check("mid_rst_last",  ifa.out_last, 0);
      check("mid_rst_ready", ifa.in_ready, 0);
      seen_done = 0;
      for (int i = 0; i < 4; i++) begin
         seen_done |= ifa.done;
         cyc();
      end
      check("mid_rst_no_done", seen_done, 0);
      op_a(0, 1, Q1, 0, 0, '0);

      // Out-of-range first operand: completion and timing only for that slot.
      op_a(8, 1, Q1, 0, 0, '0);

      // Random backpressure on the 8-coefficient instance.
      ifb.start = 1'b1; ifb.q_in = Q1;
      cyc();
      ifb.start = 1'b0; ifb.q_in = 54'd5;
      sent = 0; got = 0; dones = 0; quiet = 0; pstall = 0; pout = '0; plast = 0;
      for (int c = 0; c < 400 && quiet < 4; c++) begin
         if (ifb.done) dones++;
         ifb.in_valid  = (sent < 8) && ($urandom_range(0, 1) == 1);
         if (sent < 8) begin
            ifb.ina = vt[12+sent].a;
            ifb.inb = vt[12+sent].b;
         end
         ifb.out_ready = ($urandom_range(0, 1) == 1);
         #1;
         if (pstall) begin
            check("bp_hold_valid", ifb.out_valid, 1);
            check("bp_hold_out",   ifb.out, pout);
            check("bp_hold_last",  ifb.out_last, plast);
         end
         pstall = ifb.out_valid && !ifb.out_ready;
         pout   = ifb.out;
         plast  = ifb.out_last;
         if (ifb.out_valid && ifb.out_ready) begin
            if (got < 8) begin
               check("bp_out",  ifb.out, vt[12+got].e);
               check("bp_last", ifb.out_last, got == 7);
            end
            got++;
         end
         if (ifb.in_valid && ifb.in_ready) sent++;
         if (got >= 8 && dones > 0) quiet++;
         cyc();
      end
      check("bp_sent",  sent, 8);
      check("bp_got",   got, 8);
      check("bp_dones", dones, 1);
      check("bp_busy",  ifb.busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
